// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Build option: DM_ARB_SPLIT_EN (see dm_arbiter.sv).
package dm_pkg;

  typedef enum logic [2:0] {
    DM_WORD  = 3'd0,
    DM_HALF  = 3'd1,
    DM_HALFU = 3'd2,
    DM_BYTE  = 3'd3,
    DM_BYTEU = 3'd4
  } dm_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_RESP  = 2'd3
  } dm_state_e;

  // Word count for the default 7-bit byte address.
  localparam int DM_AW_DEFAULT = 7;
  localparam int MEM_WORDS     = 2 ** (DM_AW_DEFAULT - 2);

  // An access crosses a word boundary and needs a second beat.
  function automatic logic is_split(input logic [2:0] t, input logic [1:0] off);
    logic w_half;
    w_half = (t == DM_HALF) || (t == DM_HALFU);
    return ((t == DM_WORD) && (off != 2'd0)) || (w_half && (off == 2'd3));
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane steering: store masks/data for both beats, and load merge/extend.
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [2:0]  i_type,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be0,
  output logic [3:0]  o_be1,
  output logic [31:0] o_wdata0,
  output logic [31:0] o_wdata1,
  input  logic [31:0] i_rdata_lo,
  input  logic [31:0] i_rdata_hi,
  output logic [31:0] o_rdata
);

  logic [3:0]  w_size_mask;
  logic [7:0]  w_mask8;
  logic [63:0] w_wide;
  logic [31:0] w_merged;

  always_comb begin
    w_size_mask = 4'b0001;
    case (i_type)
      DM_WORD:           w_size_mask = 4'b1111;
      DM_HALF, DM_HALFU: w_size_mask = 4'b0011;
      default:           w_size_mask = 4'b0001;
    endcase
  end

  // Shifting across 8 lanes yields beat 0 in the low half, beat 1 in the high half.
  assign w_mask8  = {4'b0000, w_size_mask} << i_off;
  assign w_wide   = {32'd0, i_wdata} << {i_off, 3'b000};
  assign o_be0    = w_mask8[3:0];
  assign o_be1    = w_mask8[7:4];
  assign o_wdata0 = w_wide[31:0];
  assign o_wdata1 = w_wide[63:32];

  assign w_merged = 32'({i_rdata_hi, i_rdata_lo} >> {i_off, 3'b000});

  always_comb begin
    o_rdata = {24'd0, w_merged[7:0]};
    case (i_type)
      DM_WORD:  o_rdata = w_merged;
      DM_HALF:  o_rdata = {{16{w_merged[15]}}, w_merged[15:0]};
      DM_HALFU: o_rdata = {16'd0, w_merged[15:0]};
      DM_BYTE:  o_rdata = {{24{w_merged[7]}}, w_merged[7:0]};
      default:  o_rdata = {24'd0, w_merged[7:0]};
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter and beat sequencer for the word data memory.
// DM_ARB_SPLIT_EN defined: misaligned accesses take two beats; undefined: they fault (respN_err).
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int AW = 7,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [2:0]    req0_type,
  input  logic [DW-1:0] req0_wdata,
  output logic          resp0_valid,
  output logic [DW-1:0] resp0_rdata,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [2:0]    req1_type,
  input  logic [DW-1:0] req1_wdata,
  output logic          resp1_valid,
  output logic [DW-1:0] resp1_rdata,
  output logic [AW-3:0] mem_addr,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
`ifndef DM_ARB_SPLIT_EN
  output logic          resp0_err,
  output logic          resp1_err,
`endif
  output logic [1:0]    o_dbg_state
);

  // Handshake: a request transfers on a rising edge where reqN_valid and reqN_ready
  // are both high. ready is only offered in IDLE, to the granted port, outside reset;
  // a waiting requester holds valid and its payload stable until it sees ready.

  dm_state_e     r_state, w_next;
  logic          r_last_grant, r_port, r_we, r_split;
  logic [AW-1:0] r_addr;
  logic [2:0]    r_type;
  logic [31:0]   r_wdata, r_lo;
  logic          r_resp_valid0, r_resp_valid1;
  logic [31:0]   r_resp_rdata0, r_resp_rdata1;

  logic          w_grant, w_accept, w_in_split;
  logic [AW-1:0] w_in_addr;
  logic [2:0]    w_in_type;
  logic          w_do_split, w_fault;
  logic [AW-3:0] w_word_idx;
  logic [3:0]    w_be0, w_be1;
  logic [31:0]   w_wd0, w_wd1, w_lo, w_align_rdata, w_resp_data;

  // Contention goes to the port that did not win last; a lone requester always wins.
  assign w_grant    = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
  assign w_accept   = rstn && (r_state == ST_IDLE) && (req0_valid || req1_valid);
  assign req0_ready = w_accept && !w_grant;
  assign req1_ready = w_accept && w_grant;

  assign w_in_addr  = w_grant ? req1_addr : req0_addr;
  assign w_in_type  = w_grant ? req1_type : req0_type;
  assign w_in_split = is_split(w_in_type, w_in_addr[1:0]);

`ifdef DM_ARB_SPLIT_EN
  assign w_do_split = r_split;
  assign w_fault    = 1'b0;
`else
  assign w_do_split = 1'b0;
  assign w_fault    = r_split;
`endif

  assign w_word_idx = r_addr[AW-1:2];
  assign w_lo       = w_do_split ? r_lo : mem_rdata;

  dm_lane_align u_align (
    .i_type     (r_type),
    .i_off      (r_addr[1:0]),
    .i_wdata    (r_wdata),
    .o_be0      (w_be0),
    .o_be1      (w_be1),
    .o_wdata0   (w_wd0),
    .o_wdata1   (w_wd1),
    .i_rdata_lo (w_lo),
    .i_rdata_hi (mem_rdata),
    .o_rdata    (w_align_rdata)
  );

  assign w_resp_data = (r_we || w_fault) ? 32'd0 : w_align_rdata;

  always_comb begin
    w_next    = r_state;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_wdata = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next = ST_BEAT0;
      end
      ST_BEAT0: begin
        mem_addr = w_word_idx;
        if (r_we && !w_fault) begin
          mem_we    = 1'b1;
          mem_be    = w_be0;
          mem_wdata = w_wd0;
        end
        w_next = w_do_split ? ST_BEAT1 : ST_RESP;
      end
      ST_BEAT1: begin
        // Natural overflow of the word index wraps the top word to word 0.
        mem_addr = w_word_idx + (AW-2)'(1);
        if (r_we) begin
          mem_we    = 1'b1;
          mem_be    = w_be1;
          mem_wdata = w_wd1;
        end
        w_next = ST_RESP;
      end
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state       <= ST_IDLE;
      r_last_grant  <= 1'b1;
      r_port        <= 1'b0;
      r_we          <= 1'b0;
      r_split       <= 1'b0;
      r_addr        <= '0;
      r_type        <= '0;
      r_wdata       <= '0;
      r_lo          <= '0;
      r_resp_valid0 <= 1'b0;
      r_resp_valid1 <= 1'b0;
      r_resp_rdata0 <= '0;
      r_resp_rdata1 <= '0;
    end else begin
      r_state       <= w_next;
      r_resp_valid0 <= 1'b0;
      r_resp_valid1 <= 1'b0;
      if (w_accept) begin
        r_we         <= w_grant ? req1_we : req0_we;
        r_wdata      <= w_grant ? req1_wdata : req0_wdata;
        r_addr       <= w_in_addr;
        r_type       <= w_in_type;
        r_split      <= w_in_split;
        r_port       <= w_grant;
        r_last_grant <= w_grant;
      end
      if (r_state == ST_BEAT1) r_lo <= mem_rdata;
      if (r_state == ST_RESP) begin
        if (r_port) begin
          r_resp_valid1 <= 1'b1;
          r_resp_rdata1 <= w_resp_data;
        end else begin
          r_resp_valid0 <= 1'b1;
          r_resp_rdata0 <= w_resp_data;
        end
      end
    end
  end

`ifndef DM_ARB_SPLIT_EN
  logic r_err0, r_err1;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_err0 <= 1'b0;
      r_err1 <= 1'b0;
    end else begin
      r_err0 <= (r_state == ST_RESP) && !r_port && w_fault;
      r_err1 <= (r_state == ST_RESP) && r_port && w_fault;
    end
  end

  assign resp0_err = r_err0;
  assign resp1_err = r_err1;
`endif

  assign resp0_valid = r_resp_valid0;
  assign resp1_valid = r_resp_valid1;
  assign resp0_rdata = r_resp_rdata0;
  assign resp1_rdata = r_resp_rdata1;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: directed requests, bench-side memory model,
// decoupled monitor checking writes, grants, responses and latency.
module tb_dm_arbiter;
  import dm_pkg::*;

  localparam int AW = 7;
  localparam int W  = 41;  // {err, latency[7:0], rdata[31:0]}

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          req0_valid, req0_ready, req0_we, resp0_valid;
  logic [AW-1:0] req0_addr;
  logic [2:0]    req0_type;
  logic [31:0]   req0_wdata, resp0_rdata;
  logic          req1_valid, req1_ready, req1_we, resp1_valid;
  logic [AW-1:0] req1_addr;
  logic [2:0]    req1_type;
  logic [31:0]   req1_wdata, resp1_rdata;
  logic [AW-3:0] mem_addr;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'd0;
  logic          err0, err1;
  logic [1:0]    dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [W-1:0]  exp_q0[$];
  logic [W-1:0]  exp_q1[$];
  logic [40:0]   exp_wr_q[$];  // {word index[4:0], be[3:0], data[31:0]}
  logic          exp_grant_q[$];
  int            acc_q0[$];
  int            acc_q1[$];
  logic [31:0]   mem [32];

  dm_arbiter #(.AW(AW), .DW(32)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_we     (req0_we),
    .req0_addr   (req0_addr),
    .req0_type   (req0_type),
    .req0_wdata  (req0_wdata),
    .resp0_valid (resp0_valid),
    .resp0_rdata (resp0_rdata),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_we     (req1_we),
    .req1_addr   (req1_addr),
    .req1_type   (req1_type),
    .req1_wdata  (req1_wdata),
    .resp1_valid (resp1_valid),
    .resp1_rdata (resp1_rdata),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_be      (mem_be),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
`ifndef DM_ARB_SPLIT_EN
    .resp0_err   (err0),
    .resp1_err   (err1),
`endif
    .o_dbg_state (dbg_state)
  );

`ifdef DM_ARB_SPLIT_EN
  assign err0 = 1'b0;
  assign err1 = 1'b0;
`endif

  // ---------------- clock / reset / memory model ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
  end

  always @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    mem_rdata <= mem[mem_addr];
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] bmask(input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
    return m;
  endfunction

  task automatic check_resp(input int p, input logic [31:0] rd, input logic er);
    logic [W-1:0] e;
    int           a;
    int           n;
    n = (p == 0) ? exp_q0.size() : exp_q1.size();
    if (n == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_resp port %0d: got rdata 0x%08h, expected no response", p, rd);
    end else begin
      if (p == 0) begin
        e = exp_q0.pop_front();
        a = (acc_q0.size() > 0) ? acc_q0.pop_front() : -100;
      end else begin
        e = exp_q1.pop_front();
        a = (acc_q1.size() > 0) ? acc_q1.pop_front() : -100;
      end
      chk((p == 0) ? "resp0_rdata" : "resp1_rdata", rd, e[31:0]);
      chk((p == 0) ? "resp0_err" : "resp1_err", 32'(er), 32'(e[40]));
      chk((p == 0) ? "resp0_latency" : "resp1_latency", 32'(cyc - a), 32'(e[39:32]));
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [40:0] w;
    if (req0_valid && req0_ready) begin
      acc_q0.push_back(cyc);
      if (exp_grant_q.size() > 0) chk("grant_order", 32'd0, 32'(exp_grant_q.pop_front()));
    end
    if (req1_valid && req1_ready) begin
      acc_q1.push_back(cyc);
      if (exp_grant_q.size() > 0) chk("grant_order", 32'd1, 32'(exp_grant_q.pop_front()));
    end
    if (req0_ready || req1_ready) begin
      chk("ready_only_in_idle", 32'(dbg_state), 32'(ST_IDLE));
      chk("ready_onehot", 32'(req0_ready && req1_ready), 32'd0);
    end
    if (mem_we) begin
      if (exp_wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: idx %0d be %b data 0x%08h", mem_addr, mem_be, mem_wdata);
      end else begin
        w = exp_wr_q.pop_front();
        chk("wr_index", 32'(mem_addr), 32'(w[40:36]));
        chk("wr_be", 32'(mem_be), 32'(w[35:32]));
        chk("wr_data", mem_wdata & bmask(mem_be), w[31:0] & bmask(w[35:32]));
      end
    end else begin
      chk("be_zero_without_we", 32'(mem_be), 32'd0);
    end
    if (resp0_valid) check_resp(0, resp0_rdata, err0);
    if (resp1_valid) check_resp(1, resp1_rdata, err1);
  end

  // ---------------- driver tasks ----------------
  task automatic expect_resp(input int p, input logic [31:0] rd, input logic er, input int lat);
    if (p == 0) exp_q0.push_back({er, 8'(lat), rd});
    else        exp_q1.push_back({er, 8'(lat), rd});
  endtask

  task automatic expect_wr(input int idx, input logic [3:0] be, input logic [31:0] d);
    exp_wr_q.push_back({5'(idx), be, d});
  endtask

  // Holds valid until ready is seen, then returns #1 after the accepting edge.
  task automatic send(input int p, input logic we, input logic [AW-1:0] addr,
                      input logic [2:0] t, input logic [31:0] wd);
    bit ok;
    ok = 1'b0;
    if (p == 0) begin
      req0_we = we; req0_addr = addr; req0_type = t; req0_wdata = wd; req0_valid = 1'b1;
    end else begin
      req1_we = we; req1_addr = addr; req1_type = t; req1_wdata = wd; req1_valid = 1'b1;
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((p == 0) ? req0_ready : req1_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout port %0d: got no ready, expected ready within 50 cycles", p);
    end
    @(posedge clk);
    #1;
    if (p == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q0.size() + exp_q1.size() + exp_wr_q.size() + exp_grant_q.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(exp_q0.size() + exp_q1.size() + exp_wr_q.size() + exp_grant_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_req0_ready", 32'(req0_ready), 32'd0);
    chk("rst_req1_ready", 32'(req1_ready), 32'd0);
    chk("rst_resp0_valid", 32'(resp0_valid), 32'd0);
    chk("rst_resp1_valid", 32'(resp1_valid), 32'd0);
    chk("rst_resp0_rdata", resp0_rdata, 32'd0);
    chk("rst_resp1_rdata", resp1_rdata, 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
`ifndef DM_ARB_SPLIT_EN
    chk("rst_resp0_err", 32'(err0), 32'd0);
    chk("rst_resp1_err", 32'(err1), 32'd0);
`endif
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_type = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_type = '0; req1_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;

    // Aligned word store/load round trip on port 0.
    expect_wr(2, 4'b1111, 32'hDEAD_BEEF);
    expect_resp(0, 32'd0, 1'b0, 3);
    send(0, 1'b1, 7'h08, DM_WORD, 32'hDEAD_BEEF);
    expect_resp(0, 32'hDEAD_BEEF, 1'b0, 3);
    send(0, 1'b0, 7'h08, DM_WORD, 32'd0);

    // Port 1 seeds word 1 = 0x000080FF, then extension cases on port 0.
    expect_wr(1, 4'b1111, 32'h0000_80FF);
    expect_resp(1, 32'd0, 1'b0, 3);
    send(1, 1'b1, 7'h04, DM_WORD, 32'h0000_80FF);
    drain();
    expect_resp(0, 32'hFFFF_FFFF, 1'b0, 3); send(0, 1'b0, 7'h04, DM_BYTE,  32'd0);
    expect_resp(0, 32'h0000_00FF, 1'b0, 3); send(0, 1'b0, 7'h04, DM_BYTEU, 32'd0);
    expect_resp(0, 32'h0000_80FF, 1'b0, 3); send(0, 1'b0, 7'h04, DM_HALFU, 32'd0);
    expect_resp(0, 32'hFFFF_80FF, 1'b0, 3); send(0, 1'b0, 7'h04, DM_HALF,  32'd0);
    expect_resp(0, 32'hFFFF_FF80, 1'b0, 3); send(0, 1'b0, 7'h05, DM_BYTE,  32'd0);
    expect_resp(0, 32'h0000_0080, 1'b0, 3); send(0, 1'b0, 7'h05, DM_HALF,  32'd0);
    expect_resp(0, 32'h0000_0080, 1'b0, 3); send(0, 1'b0, 7'h05, 3'd7,     32'd0);
    expect_resp(0, 32'h0000_0000, 1'b0, 3); send(0, 1'b0, 7'h06, DM_BYTE,  32'd0);

    // Sub-word stores into the top word, then read back as a word.
    expect_wr(31, 4'b0010, 32'h0000_5A00);
    expect_resp(1, 32'd0, 1'b0, 3);
    send(1, 1'b1, 7'h7D, DM_BYTE, 32'h1234_565A);
    expect_wr(31, 4'b1100, 32'hABCD_0000);
    expect_resp(1, 32'd0, 1'b0, 3);
    send(1, 1'b1, 7'h7E, DM_HALF, 32'h0000_ABCD);
    drain();
    expect_resp(0, 32'hABCD_5A00, 1'b0, 3);
    send(0, 1'b0, 7'h7C, DM_WORD, 32'd0);
    drain();

`ifdef DM_ARB_SPLIT_EN
    // Misaligned word store/load across words 1 and 2.
    expect_wr(1, 4'b1000, 32'h4400_0000);
    expect_wr(2, 4'b0111, 32'h0011_2233);
    expect_resp(0, 32'd0, 1'b0, 4);
    send(0, 1'b1, 7'h07, DM_WORD, 32'h1122_3344);
    expect_resp(0, 32'h1122_3344, 1'b0, 4);
    send(0, 1'b0, 7'h07, DM_WORD, 32'd0);
    expect_resp(0, 32'hDE11_2233, 1'b0, 3);
    send(0, 1'b0, 7'h08, DM_WORD, 32'd0);
    // Halfword at the last byte wraps to word 0.
    expect_wr(31, 4'b1000, 32'hCD00_0000);
    expect_wr(0, 4'b0001, 32'h0000_00AB);
    expect_resp(1, 32'd0, 1'b0, 4);
    send(1, 1'b1, 7'h7F, DM_HALF, 32'h0000_ABCD);
    expect_resp(1, 32'h0000_ABCD, 1'b0, 4);
    send(1, 1'b0, 7'h7F, DM_HALFU, 32'd0);
`else
    // Misaligned accesses fault: no write, zero data, err with the pulse.
    expect_resp(0, 32'd0, 1'b1, 3);
    send(0, 1'b0, 7'h02, DM_WORD, 32'd0);
    expect_resp(0, 32'd0, 1'b1, 3);
    send(0, 1'b1, 7'h07, DM_WORD, 32'h1122_3344);
    expect_resp(1, 32'd0, 1'b1, 3);
    send(1, 1'b1, 7'h7F, DM_HALF, 32'h0000_ABCD);
    expect_resp(1, 32'd0, 1'b1, 3);
    send(1, 1'b0, 7'h7F, DM_HALFU, 32'd0);
    expect_resp(0, 32'h0000_80FF, 1'b0, 3);
    send(0, 1'b0, 7'h04, DM_WORD, 32'd0);
    expect_resp(0, 32'hDEAD_BEEF, 1'b0, 3);
    send(0, 1'b0, 7'h08, DM_WORD, 32'd0);
`endif
    drain();

    // Fresh reset so port 0 wins first, then both ports contend continuously.
    rstn = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    exp_grant_q.push_back(1'b0);
    exp_grant_q.push_back(1'b1);
    exp_grant_q.push_back(1'b0);
    exp_grant_q.push_back(1'b1);
    expect_resp(0, 32'h0000_00FF, 1'b0, 3);
    expect_resp(0, 32'hFFFF_80FF, 1'b0, 3);
    expect_resp(1, 32'hFFFF_FF80, 1'b0, 3);
    expect_resp(1, 32'h0000_80FF, 1'b0, 3);
    fork
      begin
        send(0, 1'b0, 7'h04, DM_BYTEU, 32'd0);
        send(0, 1'b0, 7'h04, DM_HALF, 32'd0);
      end
      begin
        send(1, 1'b0, 7'h05, DM_BYTE, 32'd0);
        send(1, 1'b0, 7'h04, DM_HALFU, 32'd0);
      end
    join
    drain();

    // Reset during BEAT0 of a store: only the beat-0 write, no response.
`ifdef DM_ARB_SPLIT_EN
    expect_wr(4, 4'b1110, 32'h6677_8800);
    send(0, 1'b1, 7'h11, DM_WORD, 32'h5566_7788);
`else
    expect_wr(4, 4'b1111, 32'h5566_7788);
    send(0, 1'b1, 7'h10, DM_WORD, 32'h5566_7788);
`endif
    chk("beat0_state_at_reset", 32'(dbg_state), 32'(ST_BEAT0));
    rstn = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    acc_q0.delete();
    @(negedge clk);
    check_reset_outputs();
    repeat (10) @(posedge clk);
    #1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
